// File: rtl/zip_div_iter_if.sv
// Handshake/bus bundle for the iterative divider; master issues divides, slave is the divider.
// o_remainder exists only when ZIPDIV_REMAINDER_EN is defined.
interface zip_div_iter_if #(
  parameter int BW = 32
);
  logic          i_wr;
  logic          i_signed;
  logic [BW-1:0] i_numerator;
  logic [BW-1:0] i_denominator;
  logic          o_busy;
  logic          o_valid;
  logic          o_err;
  logic [BW-1:0] o_quotient;
  logic [3:0]    o_flags;
`ifdef ZIPDIV_REMAINDER_EN
  logic [BW-1:0] o_remainder;
`endif

  modport master (
    output i_wr, i_signed, i_numerator, i_denominator,
`ifdef ZIPDIV_REMAINDER_EN
    input  o_remainder,
`endif
    input  o_busy, o_valid, o_err, o_quotient, o_flags
  );

  modport slave (
    input  i_wr, i_signed, i_numerator, i_denominator,
`ifdef ZIPDIV_REMAINDER_EN
    output o_remainder,
`endif
    output o_busy, o_valid, o_err, o_quotient, o_flags
  );
endinterface

// File: rtl/zip_div_iter.sv
// Iterative shift-subtract divider, one quotient bit per clock, fixed BW+2 cycle latency.
// Define ZIPDIV_REMAINDER_EN to add a C-semantics remainder output.
module zip_div_iter #(
  parameter int BW   = 32,
  parameter int LGBW = 5
) (
  input  logic        i_clk,
  input  logic        i_reset,
  zip_div_iter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DIV,
    S_DONE
  } state_t;

  state_t           state;
  logic             op_signed;
  logic             q_neg;
  logic [LGBW-1:0]  count;
  logic [BW-1:0]    dividend;
  logic [2*BW-2:0]  divisor;
  logic [BW-1:0]    quo;
`ifdef ZIPDIV_REMAINDER_EN
  logic             num_neg_q;
`endif

  logic             num_neg;
  logic             den_neg;
  logic             take;
  logic [BW-1:0]    quo_next;
  logic [BW-1:0]    rem_next;

  // Any bit of the shifted divisor above the BW-bit comparator window means it cannot fit.
  assign take     = (divisor[2*BW-2:BW] == '0) && (dividend >= divisor[BW-1:0]);
  assign quo_next = {quo[BW-2:0], take};
  assign rem_next = take ? (dividend - divisor[BW-1:0]) : dividend;
  assign num_neg  = op_signed & dividend[BW-1];
  assign den_neg  = op_signed & divisor[BW-1];

  assign bus.o_flags = bus.o_valid ? {1'b0, bus.o_quotient[BW-1], 1'b0, (bus.o_quotient == '0)}
                                   : 4'b0000;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= S_IDLE;
      op_signed      <= 1'b0;
      q_neg          <= 1'b0;
      count          <= '0;
      dividend       <= '0;
      divisor        <= '0;
      quo            <= '0;
      bus.o_busy     <= 1'b0;
      bus.o_valid    <= 1'b0;
      bus.o_err      <= 1'b0;
      bus.o_quotient <= '0;
`ifdef ZIPDIV_REMAINDER_EN
      num_neg_q       <= 1'b0;
      bus.o_remainder <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          bus.o_valid <= 1'b0;
          bus.o_err   <= 1'b0;
          if (bus.i_wr) begin
            op_signed  <= bus.i_signed;
            dividend   <= bus.i_numerator;
            divisor    <= {{(BW-1){1'b0}}, bus.i_denominator};
            bus.o_busy <= 1'b1;
            state      <= S_PRE;
          end else begin
            state <= S_IDLE;
          end
        end

        S_PRE: begin
          q_neg    <= num_neg ^ den_neg;
          dividend <= num_neg ? -dividend : dividend;
          divisor  <= {(den_neg ? -divisor[BW-1:0] : divisor[BW-1:0]), {(BW-1){1'b0}}};
          count    <= LGBW'(BW-1);
          quo      <= '0;
`ifdef ZIPDIV_REMAINDER_EN
          num_neg_q <= num_neg;
`endif
          if (divisor[BW-1:0] == '0) begin
            bus.o_busy     <= 1'b0;
            bus.o_valid    <= 1'b1;
            bus.o_err      <= 1'b1;
            bus.o_quotient <= '0;
`ifdef ZIPDIV_REMAINDER_EN
            bus.o_remainder <= '0;
`endif
            state          <= S_DONE;
          end else begin
            state <= S_DIV;
          end
        end

        S_DIV: begin
          dividend <= rem_next;
          divisor  <= divisor >> 1;
          quo      <= quo_next;
          count    <= count - 1'b1;
          // Sign fix-up happens here so the DONE cycle presents a final value.
          if (count == '0) begin
            bus.o_busy     <= 1'b0;
            bus.o_valid    <= 1'b1;
            bus.o_quotient <= q_neg ? -quo_next : quo_next;
`ifdef ZIPDIV_REMAINDER_EN
            bus.o_remainder <= num_neg_q ? -rem_next : rem_next;
`endif
            state          <= S_DONE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zip_div_iter.sv
// Self-checking bench for zip_div_iter: directed corner cases plus random operands vs an arithmetic model.
module tb_zip_div_iter;

  localparam int BW   = 32;
  localparam int LGBW = 5;

  logic i_clk;
  logic i_reset;
  logic rst_q;
  int   n_assert;
  int   n_fail;

  zip_div_iter_if #(.BW(BW)) dif ();

  zip_div_iter #(.BW(BW), .LGBW(LGBW)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (dif.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) rst_q <= i_reset;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain C-style integer division on 64-bit values.
  function automatic void model(input logic [BW-1:0] num, input logic [BW-1:0] den,
                                input bit sgn, output logic [BW-1:0] q,
                                output logic [BW-1:0] r, output bit err);
    longint n, d;
    if (den == '0) begin
      q = '0; r = '0; err = 1'b1;
    end else begin
      if (sgn) begin
        n = longint'($signed(num));
        d = longint'($signed(den));
      end else begin
        n = longint'({32'b0, num});
        d = longint'({32'b0, den});
      end
      q = BW'(n / d);
      r = BW'(n % d);
      err = 1'b0;
    end
  endfunction

  // Protocol invariants, checked every cycle outside reset.
  logic prev_valid, prev_busy;
  initial begin prev_valid = 1'b0; prev_busy = 1'b0; end
  always @(negedge i_clk) begin
    if (rst_q === 1'b0) begin
      chk("busy_and_valid", dif.o_busy & dif.o_valid, 1'b0);
      chk("err_without_valid", dif.o_err & ~dif.o_valid, 1'b0);
      chk("valid_two_cycles", dif.o_valid & prev_valid, 1'b0);
      chk("busy_fall_no_valid", prev_busy & ~dif.o_busy & ~dif.o_valid, 1'b0);
    end
    prev_valid = dif.o_valid;
    prev_busy  = dif.o_busy;
  end

  // Called at a negedge; returns at the negedge of the first cycle after the accept edge.
  task automatic accept(input logic [BW-1:0] num, input logic [BW-1:0] den, input bit sgn);
    dif.i_wr          = 1'b1;
    dif.i_signed      = sgn;
    dif.i_numerator   = num;
    dif.i_denominator = den;
    @(negedge i_clk);
    dif.i_wr = 1'b0;
  endtask

  // Waits (bounded) for o_valid, then checks timing and results; poke fires ignored i_wr's.
  task automatic collect(input logic [BW-1:0] num, input logic [BW-1:0] den, input bit sgn,
                         input bit poke, output logic [BW-1:0] q_out);
    logic [BW-1:0] eq, er;
    bit ee;
    int n, busy_cnt;
    model(num, den, sgn, eq, er, ee);
    n = 1;
    busy_cnt = 0;
    while (dif.o_valid !== 1'b1 && n < 80) begin
      if (dif.o_busy === 1'b1) busy_cnt++;
      if (poke && (n == 5 || n == 20)) begin
        dif.i_wr          = 1'b1;
        dif.i_signed      = 1'($urandom);
        dif.i_numerator   = $urandom;
        dif.i_denominator = $urandom_range(1, 9);
      end
      @(negedge i_clk);
      n++;
      dif.i_wr = 1'b0;
    end
    chk("latency", 64'(n), ee ? 64'd2 : 64'(BW + 2));
    chk("busy_cycles", 64'(busy_cnt), ee ? 64'd1 : 64'(BW + 1));
    chk("valid", dif.o_valid, 1'b1);
    chk("quotient", dif.o_quotient, eq);
    chk("err", dif.o_err, ee);
    chk("flags", dif.o_flags, {1'b0, eq[BW-1], 1'b0, (eq == '0)});
`ifdef ZIPDIV_REMAINDER_EN
    chk("remainder", dif.o_remainder, er);
`endif
    q_out = dif.o_quotient;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] q, num, den;
    bit sgn, saw_valid;
    n_assert = 0;
    n_fail   = 0;
    i_reset  = 1'b1;
    dif.i_wr = 1'b0;
    dif.i_signed = 1'b0;
    dif.i_numerator = '0;
    dif.i_denominator = '0;
    repeat (3) @(negedge i_clk);
    chk("rst_busy", dif.o_busy, 1'b0);
    chk("rst_valid", dif.o_valid, 1'b0);
    chk("rst_err", dif.o_err, 1'b0);
    chk("rst_quotient", dif.o_quotient, '0);
    chk("rst_flags", dif.o_flags, 4'b0000);
`ifdef ZIPDIV_REMAINDER_EN
    chk("rst_remainder", dif.o_remainder, '0);
`endif
    i_reset = 1'b0;
    @(negedge i_clk);

    accept(32'd100, 32'd7, 1'b0);
    collect(32'd100, 32'd7, 1'b0, 1'b0, q);
    chk("u100_7_literal", q, 32'd14);
    @(negedge i_clk);

    accept(-32'sd100, 32'd7, 1'b1);
    collect(-32'sd100, 32'd7, 1'b1, 1'b0, q);
    chk("s_m100_7_literal", q, 32'hFFFF_FFF2);

    accept(32'd0, 32'd5, 1'b1);
    collect(32'd0, 32'd5, 1'b1, 1'b0, q);

    accept(32'd55, 32'd0, 1'b0);
    collect(32'd55, 32'd0, 1'b0, 1'b0, q);

    accept(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    collect(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, q);
    chk("s_minint_m1_literal", q, 32'h8000_0000);

    accept(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    collect(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, q);
    @(negedge i_clk);

    // Reset at cycle 10 of an operation must abort it silently.
    accept(32'd12345, 32'd3, 1'b0);
    repeat (9) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("abort_busy", dif.o_busy, 1'b0);
    chk("abort_valid", dif.o_valid, 1'b0);
    i_reset = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dif.o_valid === 1'b1) saw_valid = 1'b1;
      @(negedge i_clk);
    end
    chk("abort_no_valid", saw_valid, 1'b0);

    accept(32'hFFFF_FFFF, 32'd1, 1'b0);
    collect(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, q);
    chk("umax_1_literal", q, 32'hFFFF_FFFF);
    @(negedge i_clk);

    // Writes while busy are ignored; a write in the valid cycle chains immediately.
    accept(32'd1000, 32'd3, 1'b0);
    collect(32'd1000, 32'd3, 1'b0, 1'b1, q);
    accept(-32'sd77, -32'sd5, 1'b1);
    collect(-32'sd77, -32'sd5, 1'b1, 1'b0, q);

    for (int i = 0; i < 24; i++) begin
      num = $urandom >> $urandom_range(0, 31);
      den = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) num = -num;
      if ($urandom_range(0, 3) == 0) den = -den;
      if (i % 6 == 5) den = '0;
      sgn = 1'($urandom_range(0, 1));
      accept(num, den, sgn);
      collect(num, den, sgn, 1'b0, q);
      if (i % 3 == 0) @(negedge i_clk);
    end

    repeat (3) @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
